// File: rtl/aes128_dec_loader.sv
// rtl/aes128_dec_loader.sv - ciphertext loader feeding the AES-128 block decryptor
//
// Packs a 32-bit ciphertext word stream into 128-bit blocks, buffers up to two
// blocks (ping-pong) and starts the non-reentrant decryptor once per block.
//
// Optional build macro: AES_LOADER_BSWAP_EN (byte-reverse each input word).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   key_we_i, key_i   key load, honoured only while idle
//   s_valid_i/s_data_i/s_ready_o  ciphertext word stream, first word = [127:96]
//   dec_ready_i, dec_done_i       decryptor handshake inputs
//   dec_start_o       one-cycle start pulse to the decryptor
//   dec_key_o         key register contents
//   dec_cipher_o      block presented to the decryptor
//   busy_o            block in flight, buffered or partially packed
//   key_err_o         one-cycle pulse when a key load is rejected
//   blk_count_o       completed blocks, wraps
module aes128_dec_loader #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_we_i,
  input  logic [127:0]      key_i,
  input  logic              s_valid_i,
  input  logic [31:0]       s_data_i,
  output logic              s_ready_o,
  input  logic              dec_ready_i,
  input  logic              dec_done_i,
  output logic              dec_start_o,
  output logic [127:0]      dec_key_o,
  output logic [127:0]      dec_cipher_o,
  output logic              busy_o,
  output logic              key_err_o,
  output logic [CNT_W-1:0]  blk_count_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic               armed_q, armed_d;
  logic [1:0]         occ_q, occ_d;
  logic               wptr_q, wptr_d;
  logic               rptr_q, rptr_d;
  logic [1:0]         wcnt_q, wcnt_d;
  logic [127:0]       ent0_q, ent0_d;
  logic [127:0]       ent1_q, ent1_d;
  logic [127:0]       key_q, key_d;
  logic               key_loaded_q, key_loaded_d;
  logic [127:0]       cipher_q, cipher_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               key_err_q, key_err_d;

  logic [31:0]        word_in;
  logic [127:0]       ent_wr;
  logic               xfer, commit, release_blk, start;

`ifdef AES_LOADER_BSWAP_EN
  assign word_in = {s_data_i[7:0], s_data_i[15:8], s_data_i[23:16], s_data_i[31:24]};
`else
  assign word_in = s_data_i;
`endif

  assign s_ready_o   = !rst && (occ_q < 2'd2);
  assign xfer        = s_valid_i && s_ready_o;
  assign commit      = xfer && (wcnt_q == 2'd3);
  assign release_blk = (state_q == ST_WAIT) && dec_done_i;
  // armed_q marks the second ISSUE cycle: the first one loads cipher_q, so the
  // decryptor always sees a settled block when start fires.
  assign start       = (state_q == ST_ISSUE) && armed_q && dec_ready_i;

  assign dec_start_o  = start;
  assign dec_key_o    = key_q;
  assign dec_cipher_o = cipher_q;
  assign busy_o       = (state_q != ST_IDLE) || (occ_q != 2'd0) || (wcnt_q != 2'd0);
  assign key_err_o    = key_err_q;
  assign blk_count_o  = count_q;

  // Entry being packed, with the incoming word merged at the current slot.
  always_comb begin
    ent_wr = wptr_q ? ent1_q : ent0_q;
    case (wcnt_q)
      2'd0:    ent_wr[127:96] = word_in;
      2'd1:    ent_wr[95:64]  = word_in;
      2'd2:    ent_wr[63:32]  = word_in;
      default: ent_wr[31:0]   = word_in;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    armed_d      = 1'b0;
    occ_d        = occ_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    wcnt_d       = wcnt_q;
    ent0_d       = ent0_q;
    ent1_d       = ent1_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    cipher_d     = cipher_q;
    count_d      = count_q;
    key_err_d    = 1'b0;

    if (xfer) begin
      if (wptr_q) ent1_d = ent_wr;
      else        ent0_d = ent_wr;
      wcnt_d = wcnt_q + 2'd1;
      if (commit) wptr_d = ~wptr_q;
    end

    // Commit and release in the same cycle cancel out.
    case ({commit, release_blk})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (key_we_i) begin
      if (state_q == ST_IDLE) begin
        key_d        = key_i;
        key_loaded_d = 1'b1;
      end else begin
        key_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        // A key written this cycle counts as loaded to save a cycle.
        if ((occ_q != 2'd0) && (key_loaded_q || key_we_i)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cipher_d = rptr_q ? ent1_q : ent0_q;
        if (start) state_d = ST_WAIT;
        else       armed_d = 1'b1;
      end
      ST_WAIT: begin
        if (release_blk) begin
          rptr_d  = ~rptr_q;
          count_d = count_q + CNT_W'(1);
          state_d = (occ_d != 2'd0) ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      occ_q        <= 2'd0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      wcnt_q       <= 2'd0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      cipher_q     <= '0;
      count_q      <= '0;
      key_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      occ_q        <= occ_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      wcnt_q       <= wcnt_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      cipher_q     <= cipher_d;
      count_q      <= count_d;
      key_err_q    <= key_err_d;
    end
  end

endmodule

// File: tb/tb_aes128_dec_loader.sv
// tb/tb_aes128_dec_loader.sv - directed self-checking bench for aes128_dec_loader
module tb_aes128_dec_loader;

  localparam int CNT_W = 16;
  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2 = 128'hffeeddccbbaa99887766554433221100;

  logic              clk = 1'b0;
  logic              rst;
  logic              key_we_i;
  logic [127:0]      key_i;
  logic              s_valid_i;
  logic [31:0]       s_data_i;
  logic              s_ready_o;
  logic              dec_ready_i;
  logic              dec_done_i;
  logic              dec_start_o;
  logic [127:0]      dec_key_o;
  logic [127:0]      dec_cipher_o;
  logic              busy_o;
  logic              key_err_o;
  logic [CNT_W-1:0]  blk_count_o;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  logic [127:0] cipher_log [0:31];
  logic [31:0]  words [0:11];

  aes128_dec_loader #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .key_we_i(key_we_i), .key_i(key_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .dec_ready_i(dec_ready_i), .dec_done_i(dec_done_i), .dec_start_o(dec_start_o),
    .dec_key_o(dec_key_o), .dec_cipher_o(dec_cipher_o),
    .busy_o(busy_o), .key_err_o(key_err_o), .blk_count_o(blk_count_o)
  );

  always #5 clk = ~clk;

  // Record every start pulse and the block presented with it.
  always @(posedge clk) begin
    if (dec_start_o) begin
      if (start_cnt < 32) cipher_log[start_cnt] = dec_cipher_o;
      start_cnt = start_cnt + 1;
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef AES_LOADER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] exp_blk(input int b);
    return {exp_word(words[4*b]), exp_word(words[4*b+1]),
            exp_word(words[4*b+2]), exp_word(words[4*b+3])};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; key_we_i = 1'b0; s_valid_i = 1'b0; dec_done_i = 1'b0; dec_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_key(input logic [127:0] k);
    key_we_i = 1'b1; key_i = k;
    @(negedge clk);
    key_we_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    int g = 0;
    s_valid_i = 1'b1; s_data_i = w;
    while (!s_ready_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (g >= 200) begin
      bad++;
      $display("FAIL push_timeout: s_ready_o=%b required 1 within 200 cycles", s_ready_o);
    end
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic push_blk(input int b);
    for (int i = 0; i < 4; i++) push(words[4*b+i]);
  endtask

  task automatic wait_start(input int n);
    int g = 0;
    while (start_cnt < n && g < 100) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (start_cnt < n) begin
      bad++;
      $display("FAIL wait_start: starts=%0d required %0d", start_cnt, n);
    end
  endtask

  task automatic do_done();
    dec_done_i = 1'b1;
    @(negedge clk);
    dec_done_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({s_ready_o, dec_start_o, busy_o, key_err_o} !== 4'b0 || blk_count_o !== '0 ||
        dec_key_o !== '0 || dec_cipher_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b start=%b busy=%b err=%b cnt=%0d required all 0",
               s_ready_o, dec_start_o, busy_o, key_err_o, blk_count_o);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL after_reset: rdy=%b busy=%b required 1 0", s_ready_o, busy_o);
    end
  endtask

  task automatic test_basic();
    int b;
    do_reset();
    load_key(KEY);
    b = start_cnt;
    dec_ready_i = 1'b0;
    push_blk(0);
    repeat (4) @(negedge clk);
    total++;
    if (start_cnt !== b || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_not_ready: starts=%0d busy=%b required %0d 1", start_cnt, busy_o, b);
    end
    dec_ready_i = 1'b1;
    wait_start(b + 1);
    total++;
    if (cipher_log[b] !== exp_blk(0)) begin
      bad++;
      $display("FAIL basic_cipher: got %h required %h", cipher_log[b], exp_blk(0));
    end
    total++;
    if (dec_key_o !== KEY || blk_count_o !== 16'd0) begin
      bad++;
      $display("FAIL basic_key_cnt: key=%h cnt=%0d required %h 0", dec_key_o, blk_count_o, KEY);
    end
    do_done();
    repeat (3) @(negedge clk);
    total++;
    if (blk_count_o !== 16'd1 || busy_o !== 1'b0 || start_cnt !== b + 1) begin
      bad++;
      $display("FAIL basic_done: cnt=%0d busy=%b starts=%0d required 1 0 %0d",
               blk_count_o, busy_o, start_cnt, b + 1);
    end
  endtask

  task automatic test_backpressure();
    int b;
    logic rdy_seen;
    do_reset();
    load_key(KEY);
    b = start_cnt;
    push_blk(0);
    push_blk(1);
    total++;
    if (s_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready_after_8: s_ready_o=%b required 0", s_ready_o);
    end
    wait_start(b + 1);
    s_valid_i = 1'b1; s_data_i = words[8];
    rdy_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (s_ready_o) rdy_seen = 1'b1;
    end
    total++;
    if (rdy_seen !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready_held: s_ready_o rose=%b required 0 before done", rdy_seen);
    end
    do_done();
    total++;
    if (s_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_after_done: s_ready_o=%b required 1", s_ready_o);
    end
    push_blk(2);
    wait_start(b + 2);
    do_done();
    wait_start(b + 3);
    do_done();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cipher_log[b+i] !== exp_blk(i)) begin
        bad++;
        $display("FAIL bp_order_%0d: got %h required %h", i, cipher_log[b+i], exp_blk(i));
      end
    end
    total++;
    if (blk_count_o !== 16'd3 || start_cnt !== b + 3 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_final: cnt=%0d starts=%0d busy=%b required 3 %0d 0",
               blk_count_o, start_cnt, busy_o, b + 3);
    end
  endtask

  task automatic test_no_key();
    int b;
    int first_k;
    do_reset();
    b = start_cnt;
    push_blk(2);
    repeat (6) @(negedge clk);
    total++;
    if (start_cnt !== b || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL nokey_idle: starts=%0d busy=%b required %0d 1", start_cnt, busy_o, b);
    end
    key_we_i = 1'b1; key_i = KEY;
    first_k = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      key_we_i = 1'b0;
      if (dec_start_o && first_k == 0) first_k = k;
    end
    total++;
    if (first_k < 1 || first_k > 2) begin
      bad++;
      $display("FAIL nokey_start_delay: start after %0d cycles required 1..2", first_k);
    end
    wait_start(b + 1);
    total++;
    if (cipher_log[b] !== exp_blk(2)) begin
      bad++;
      $display("FAIL nokey_cipher: got %h required %h", cipher_log[b], exp_blk(2));
    end
    do_done();
  endtask

  task automatic test_key_busy();
    int b;
    do_reset();
    load_key(KEY);
    b = start_cnt;
    push_blk(1);
    wait_start(b + 1);
    key_we_i = 1'b1; key_i = KEY2;
    @(negedge clk);
    key_we_i = 1'b0;
    total++;
    if (key_err_o !== 1'b1) begin
      bad++;
      $display("FAIL keyerr_pulse: key_err_o=%b required 1", key_err_o);
    end
    @(negedge clk);
    total++;
    if (key_err_o !== 1'b0 || dec_key_o !== KEY) begin
      bad++;
      $display("FAIL keyerr_after: err=%b key=%h required 0 %h", key_err_o, dec_key_o, KEY);
    end
    do_done();
    @(negedge clk);
    load_key(KEY2);
    total++;
    if (key_err_o !== 1'b0 || dec_key_o !== KEY2) begin
      bad++;
      $display("FAIL key_idle_load: err=%b key=%h required 0 %h", key_err_o, dec_key_o, KEY2);
    end
  endtask

  task automatic test_simultaneous();
    int b;
    do_reset();
    load_key(KEY);
    b = start_cnt;
    push_blk(0);
    wait_start(b + 1);
    for (int i = 4; i < 7; i++) push(words[i]);
    s_valid_i = 1'b1; s_data_i = words[7]; dec_done_i = 1'b1;
    @(negedge clk);
    s_valid_i = 1'b0; dec_done_i = 1'b0;
    total++;
    if (s_ready_o !== 1'b1 || busy_o !== 1'b1 || blk_count_o !== 16'd1 || dec_start_o !== 1'b0) begin
      bad++;
      $display("FAIL sim_occ: rdy=%b busy=%b cnt=%0d start=%b required 1 1 1 0",
               s_ready_o, busy_o, blk_count_o, dec_start_o);
    end
    @(negedge clk);
    total++;
    if (dec_start_o !== 1'b1 || dec_cipher_o !== exp_blk(1)) begin
      bad++;
      $display("FAIL sim_start_2cyc: start=%b cipher=%h required 1 %h",
               dec_start_o, dec_cipher_o, exp_blk(1));
    end
    wait_start(b + 2);
    do_done();
    @(negedge clk);
    total++;
    if (blk_count_o !== 16'd2 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL sim_final: cnt=%0d busy=%b required 2 0", blk_count_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    do_reset();
    load_key(KEY);
    b = start_cnt;
    push_blk(0);
    wait_start(b + 1);
    do_done();
    push_blk(1);
    wait_start(b + 2);
    rst = 1'b1;
    #1;
    total++;
    if ({s_ready_o, dec_start_o, busy_o, key_err_o} !== 4'b0 || blk_count_o !== '0 ||
        dec_key_o !== '0 || dec_cipher_o !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: rdy=%b busy=%b cnt=%0d key=%h cipher=%h required all 0",
               s_ready_o, busy_o, blk_count_o, dec_key_o, dec_cipher_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_key(KEY);
    b = start_cnt;
    push_blk(2);
    wait_start(b + 1);
    total++;
    if (cipher_log[b] !== exp_blk(2)) begin
      bad++;
      $display("FAIL midreset_cipher: got %h required %h", cipher_log[b], exp_blk(2));
    end
    do_done();
    total++;
    if (blk_count_o !== 16'd1) begin
      bad++;
      $display("FAIL midreset_cnt: cnt=%0d required 1", blk_count_o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    words[0] = 32'h69c4e0d8; words[1]  = 32'h6a7b0430; words[2]  = 32'hd8cdb780; words[3]  = 32'h70b4c55a;
    words[4] = 32'h01234567; words[5]  = 32'h89abcdef; words[6]  = 32'hfedcba98; words[7]  = 32'h76543210;
    words[8] = 32'hdeadbeef; words[9]  = 32'hcafef00d; words[10] = 32'h0badc0de; words[11] = 32'h13572468;
    rst = 1'b1; key_we_i = 1'b0; key_i = '0; s_valid_i = 1'b0; s_data_i = '0;
    dec_ready_i = 1'b1; dec_done_i = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_no_key();
    test_key_busy();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
